// File: rtl/reg_fifo_unit.sv
// reg_fifo_unit
//   Elastic register unit for inter-PE routes in the CGRA fabric. It is a
//   DATA_WIDTH x DEPTH synchronous FIFO with a valid/ready handshake on both
//   sides, so producer and consumer can stall independently. It also exports
//   occupancy and almost-full status for back-pressure.
//
// Ports
//   clk          fabric clock; all state changes on the rising edge
//   rst          synchronous reset, active-high (clears pointers, count, overflow)
//   en           clock enable; 0 freezes state and blocks both handshakes
//   flush        synchronous clear of pointers and count; overflow is kept
//   in_data      write data
//   in_valid     producer offers in_data
//   in_ready     unit accepts in_data this cycle
//   out_data     head entry (0 whenever out_valid is low)
//   out_valid    out_data holds a stored word
//   out_ready    consumer takes out_data this cycle
//   count        number of stored entries, 0..DEPTH
//   almost_full  count >= AFULL_LEVEL
//   overflow     sticky flag: in_valid seen while full with en=1

module reg_fifo_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  overflow
);

  localparam int            PW          = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_COUNT = CW'(AFULL_LEVEL);

  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  overflow_reg, overflow_next;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  entry_we;
  logic [DATA_WIDTH-1:0] entry_data [DEPTH];

  // Handshake qualifiers. No write-through when full: a pop in the same cycle
  // does not free a slot for the incoming word.
  assign full      = (count_reg == FULL_COUNT);
  assign empty     = (count_reg == '0);
  assign in_ready  = en & ~full;
  assign out_valid = en & ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Reset and flush discard the write so no entry is touched by a dropped word.
  assign entry_we  = push & ~flush & ~rst;

  // Storage: one register per entry, written when the write pointer selects it.
  // Contents are never cleared; the pointers alone define what is valid.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (entry_we && (wr_ptr_reg == PW'(gi))) begin
          entry_reg <= in_data;
        end
      end

      assign entry_data[gi] = entry_reg;
    end
  endgenerate

  // Head word is forced to zero when nothing valid is presented.
  assign out_data    = out_valid ? entry_data[rd_ptr_reg] : '0;
  assign count       = count_reg;
  assign almost_full = (count_reg >= AFULL_COUNT);
  assign overflow    = overflow_reg;

  // Next-state: flush > hold (en=0) > normal. Reset is applied in the
  // register block since it outranks everything.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else if (en) begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);

      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CW'(1);
      end

      if (in_valid && full) overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_reg <= FULL_COUNT)
        else $error("reg_fifo_unit: count %0d exceeds DEPTH %0d", count_reg, DEPTH);
    end
    assert (AFULL_LEVEL >= 1 && AFULL_LEVEL <= DEPTH)
      else $error("reg_fifo_unit: AFULL_LEVEL %0d outside 1..%0d", AFULL_LEVEL, DEPTH);
    assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0)
      else $error("reg_fifo_unit: DEPTH %0d is not a power of two >= 2", DEPTH);
  end
`endif

endmodule

// File: tb/tb_reg_fifo_unit.sv
// tb_reg_fifo_unit
//   Directed bench for reg_fifo_unit. A queue-based reference model tracks the
//   stored words and the sticky overflow flag; a compare process checks every
//   DUT output against it on each falling edge. The directed sequences also
//   pin a set of hand-computed literal values.

module tb_reg_fifo_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          en;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  reg_fifo_unit #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .almost_full(almost_full),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] model_q[$];
  bit            model_ovf = 1'b0;
  bit            started   = 1'b0;

  always @(posedge clk) begin
    bit can_push, can_pop;
    can_push = en && (model_q.size() != DEPTH) && in_valid;
    can_pop  = en && (model_q.size() != 0) && out_ready;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
      started   = 1'b1;
    end else if (flush) begin
      model_q.delete();
    end else if (en) begin
      if (in_valid && model_q.size() == DEPTH) model_ovf = 1'b1;
      if (can_pop) begin
        $display("tx pop  data=0x%08h", model_q[0]);
        void'(model_q.pop_front());
      end
      if (can_push) begin
        $display("tx push data=0x%08h", in_data);
        model_q.push_back(in_data);
      end
    end
  end

  // Compare process: outputs are stable away from the rising edge.
  always @(negedge clk) begin
    if (started) begin
      int sz;
      sz = model_q.size();
      chk("m_count",       DW'(count),       DW'(sz));
      chk("m_in_ready",    DW'(in_ready),    DW'(en && sz != DEPTH));
      chk("m_out_valid",   DW'(out_valid),   DW'(en && sz != 0));
      chk("m_out_data",    out_data,         (en && sz != 0) ? model_q[0] : '0);
      chk("m_almost_full", DW'(almost_full), DW'(sz >= AFULL));
      chk("m_overflow",    DW'(overflow),    DW'(model_ovf));
    end
  end

  // ---------------- stimulus ----------------
  // Advance one edge; inputs are changed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);

    // 1: reset held two cycles with in_valid high
    step(); step();
    chk("rst_count", DW'(count), 0);
    chk("rst_out_valid", DW'(out_valid), 0);
    chk("rst_in_ready", DW'(in_ready), 1);
    chk("rst_overflow", DW'(overflow), 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    // 2: fill with A0..A3, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + i, 1'b0);
      step();
      chk("fill_count", DW'(count), DW'(i + 1));
      chk("fill_afull", DW'(almost_full), DW'(i + 1 >= 3));
    end
    chk("full_in_ready", DW'(in_ready), 0);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_data", out_data, 32'hA0 + i);
      step();
    end
    chk("drain_count", DW'(count), 0);

    // 3: streaming 20 words, one per cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i, 1'b1);
      step();
      chk("stream_data", out_data, i);
      chk("stream_count", DW'(count), 1);
    end
    drive(1'b0, '0, 1'b1);
    step();
    chk("stream_empty", DW'(count), 0);

    // 4: full with simultaneous valid/ready
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hB0 + i, 1'b0);
      step();
    end
    chk("f4_count", DW'(count), 4);
    drive(1'b1, 32'hC0, 1'b1);
    step();
    chk("f4_pop_only_count", DW'(count), 3);
    chk("f4_overflow", DW'(overflow), 1);
    chk("f4_head", out_data, 32'hB1);
    step();
    chk("f4_both_count", DW'(count), 3);
    chk("f4_both_head", out_data, 32'hB2);
    chk("f4_sticky", DW'(overflow), 1);
    drive(1'b0, '0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    chk("f4_count2", DW'(count), 2);

    // 5: enable low for three cycles, then flush with a dropped input
    en = 1'b0;
    drive(1'b1, 32'h66, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("en0_in_ready", DW'(in_ready), 0);
      chk("en0_out_valid", DW'(out_valid), 0);
      chk("en0_out_data", out_data, 0);
      step();
      chk("en0_count", DW'(count), 2);
    end
    en = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h77, 1'b0);
    step();
    chk("flush_count", DW'(count), 0);
    chk("flush_out_valid", DW'(out_valid), 0);
    chk("flush_overflow_kept", DW'(overflow), 1);
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    step();
    chk("flush_dropped", DW'(count), 0);

    // 6: reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 1'b0);
      step();
    end
    chk("r6_count", DW'(count), 3);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    step();
    rst = 1'b0;
    chk("r6_count_clr", DW'(count), 0);
    chk("r6_ovf_clr", DW'(overflow), 0);
    drive(1'b1, 32'h55, 1'b0);
    step();
    drive(1'b0, '0, 1'b1);
    chk("r6_data", out_data, 32'h55);
    chk("r6_count1", DW'(count), 1);
    step();
    chk("r6_empty", DW'(count), 0);
    drive(1'b0, '0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
